// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: imem req/rsp, redirect and decode handshake bundle for the fetch stage
interface fetch_prefetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: credit-limited sequential fetch with in-order prefetch FIFO and redirect flush; FETCH_STATS_EN adds stall/flush counters
module fetch_prefetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fetch_prefetch_unit_if.master  bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            flush_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc, rsp_pc, redir_pc;
  logic [CW-1:0] outstanding, discard, count;
  logic [AW-1:0] head, tail;
  logic [63:0]   mem [FIFO_DEPTH];
  logic          credit, accept, drop, push, pop, redir;
  assign redir    = bus.redirect_valid;
  assign redir_pc = bus.redirect_pc & ~32'h3;
  assign credit   = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
  assign bus.imem_req_valid = reset_n && !redir && credit;
  assign bus.imem_req_addr  = fetch_pc;
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign drop   = bus.imem_rsp_valid && discard != '0;
  // a response landing in a redirect cycle belongs to the old stream
  assign push   = bus.imem_rsp_valid && discard == '0 && !redir;
  assign bus.if_valid = count != '0;
  assign pop    = bus.if_valid && bus.if_ready && !redir;
  assign {bus.if_pc, bus.if_instr} = bus.if_valid ? mem[head] : 64'h0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(bus.imem_rsp_valid);
      fetch_pc    <= redir ? redir_pc : accept ? fetch_pc + 32'd4 : fetch_pc;
      rsp_pc      <= redir ? redir_pc : push ? rsp_pc + 32'd4 : rsp_pc;
      discard     <= redir ? outstanding - CW'(bus.imem_rsp_valid) : discard - CW'(drop);
      count       <= redir ? '0 : count + CW'(push) - CW'(pop);
      head        <= redir ? '0 : head + AW'(pop);
      tail        <= redir ? '0 : tail + AW'(push);
    end
  always_ff @(posedge clk)
    if (push) mem[tail] <= {rsp_pc, bus.imem_rsp_data};
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= (!bus.if_valid && bus.if_ready && stall_cycles != '1) ? stall_cycles + 32'd1 : stall_cycles;
      flush_count  <= (redir && flush_count != '1) ? flush_count + 32'd1 : flush_count;
    end
`endif
endmodule
